// File: rtl/up_rr_arb.sv
// Round-robin arbiter sharing one microprocessor slave bus among N_PORT masters.
// Each master gets one access per grant; a stalled slave is released by a timeout counter.
module up_rr_arb #(
    parameter int                N_PORT    = 2,
    parameter int                G_CPUA    = 30,
    parameter int                G_CPUW    = 32,
    parameter int                TIMEOUT_W = 8,
    parameter logic [G_CPUW-1:0] TIMEOUT_D = 32'hCAFE_CAFE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_PORT*G_CPUA-1:0] m_upa,
    input  logic [N_PORT-1:0]        m_upen,
    input  logic [N_PORT-1:0]        m_upws,
    input  logic [N_PORT-1:0]        m_uprs,
    input  logic [N_PORT*G_CPUW-1:0] m_updi,
    output logic [G_CPUW-1:0]        m_updo,
    output logic [N_PORT-1:0]        m_uprdy,
    output logic [N_PORT-1:0]        m_uperr,
    output logic [G_CPUA-1:0]        s_upa,
    output logic                     s_upen,
    output logic                     s_upws,
    output logic                     s_uprs,
    output logic [G_CPUW-1:0]        s_updi,
    input  logic [G_CPUW-1:0]        s_updo,
    input  logic                     s_uprdy,
    output logic [N_PORT-1:0]        grant,
    output logic                     busy
);

    localparam int IW = (N_PORT > 1) ? $clog2(N_PORT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           r_state;
    logic [N_PORT-1:0]    r_pend;
    logic [N_PORT-1:0]    r_pend_wr;
    logic [N_PORT-1:0]    r_grant;
    logic [N_PORT-1:0]    r_uprdy;
    logic [N_PORT-1:0]    r_uperr;
    logic [IW-1:0]        r_last;
    logic                 r_gwr;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic [G_CPUA-1:0]    r_upa;
    logic [G_CPUW-1:0]    r_updi;
    logic [G_CPUW-1:0]    r_updo;

    logic [N_PORT-1:0]    w_strb;
    logic [N_PORT-1:0]    w_abort;
    logic [N_PORT-1:0]    w_clr;
    logic [N_PORT-1:0]    w_req;
    logic                 w_any;
    logic [IW-1:0]        w_win;
    logic [IW-1:0]        w_cidx;
    logic                 w_fin;
    logic [G_CPUA-1:0]    w_sel_a;
    logic [G_CPUW-1:0]    w_sel_d;
    logic [N_PORT-1:0]    w_win_oh;

    // A strobe only registers on a port that is neither queued nor being served.
    assign w_strb  = (m_upws | m_uprs) & m_upen & ~r_pend & ~r_grant;
    assign w_abort = r_pend & ~r_grant & ~m_upen;
    assign w_fin   = (r_state == S_WAIT) && (s_uprdy || (&r_cnt));
    assign w_clr   = w_fin ? r_grant : '0;
    assign w_req   = r_pend & m_upen;

    always_comb begin
        w_any  = 1'b0;
        w_win  = r_last;
        w_cidx = '0;
        for (int k = 1; k <= N_PORT; k++) begin
            w_cidx = IW'((int'(r_last) + k) % N_PORT);
            if (!w_any && w_req[w_cidx]) begin
                w_any = 1'b1;
                w_win = w_cidx;
            end
        end
    end

    always_comb begin
        w_sel_a  = '0;
        w_sel_d  = '0;
        w_win_oh = '0;
        for (int i = 0; i < N_PORT; i++) begin
            if (w_win == IW'(i)) begin
                w_sel_a     = m_upa[i*G_CPUA +: G_CPUA];
                w_sel_d     = m_updi[i*G_CPUW +: G_CPUW];
                w_win_oh[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend    <= '0;
            r_pend_wr <= '0;
        end else begin
            r_pend    <= (r_pend & ~w_abort & ~w_clr) | w_strb;
            r_pend_wr <= (r_pend_wr & ~w_strb) | (m_upws & w_strb);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= IW'(N_PORT - 1);
            r_gwr   <= 1'b0;
            r_cnt   <= '0;
            r_upa   <= '0;
            r_updi  <= '0;
            r_updo  <= '0;
            r_uprdy <= '0;
            r_uperr <= '0;
        end else begin
            r_uprdy <= '0;
            r_uperr <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win_oh;
                        r_last  <= w_win;
                        r_gwr   <= r_pend_wr[w_win];
                        r_upa   <= w_sel_a;
                        r_updi  <= w_sel_d;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Slave ready takes precedence over a timeout in the same cycle.
                    if (s_uprdy) begin
                        if (!r_gwr) r_updo <= s_updo;
                        r_uprdy <= r_grant;
                        r_grant <= '0;
                        r_state <= S_DONE;
                    end else if (&r_cnt) begin
                        if (!r_gwr) r_updo <= TIMEOUT_D;
                        r_uprdy <= r_grant;
                        r_uperr <= r_grant;
                        r_grant <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_upen  = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign s_upws  = (r_state == S_ISSUE) && r_gwr;
    assign s_uprs  = (r_state == S_ISSUE) && !r_gwr;
    assign busy    = (r_state != S_IDLE);
    assign grant   = r_grant;
    assign s_upa   = r_upa;
    assign s_updi  = r_updi;
    assign m_updo  = r_updo;
    assign m_uprdy = r_uprdy;
    assign m_uperr = r_uperr;

endmodule

// File: tb/tb_up_rr_arb.sv
// Scoreboard bench for up_rr_arb: directed accesses push expected completions,
// a monitor pops them whenever m_uprdy pulses; a behavioural slave logs every bus access.
module tb_up_rr_arb;

    localparam int NP = 2;
    localparam int A  = 30;
    localparam int W  = 32;
    localparam int TW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NP*A-1:0] m_upa = '0;
    logic [NP-1:0]   m_upen = '0;
    logic [NP-1:0]   m_upws = '0;
    logic [NP-1:0]   m_uprs = '0;
    logic [NP*W-1:0] m_updi = '0;
    logic [W-1:0]    m_updo;
    logic [NP-1:0]   m_uprdy;
    logic [NP-1:0]   m_uperr;
    logic [A-1:0]    s_upa;
    logic            s_upen;
    logic            s_upws;
    logic            s_uprs;
    logic [W-1:0]    s_updi;
    logic [W-1:0]    s_updo = '0;
    logic            s_uprdy = 1'b0;
    logic [NP-1:0]   grant;
    logic            busy;

    up_rr_arb #(
        .N_PORT(NP), .G_CPUA(A), .G_CPUW(W), .TIMEOUT_W(TW), .TIMEOUT_D(32'hCAFE_CAFE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_upa(m_upa), .m_upen(m_upen), .m_upws(m_upws), .m_uprs(m_uprs), .m_updi(m_updi),
        .m_updo(m_updo), .m_uprdy(m_uprdy), .m_uperr(m_uperr),
        .s_upa(s_upa), .s_upen(s_upen), .s_upws(s_upws), .s_uprs(s_uprs), .s_updi(s_updi),
        .s_updo(s_updo), .s_uprdy(s_uprdy),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [NP-1:0] port;
        logic          err;
        logic [W-1:0]  data;
    } exp_t;

    typedef struct {
        int            c_iss;
        logic [NP-1:0] gnt;
        logic          wr;
        logic [A-1:0]  addr;
        logic [W-1:0]  wdata;
    } acc_t;

    exp_t       sb[$];
    acc_t       slog[$];
    int         rdy_log[$];
    int         total = 0;
    int         bad = 0;
    int         last_rdy_cyc = 0;
    int         t0 = 0;
    logic [W-1:0] exp_updo = '0;

    bit         sl_never = 1'b0;
    bit         sl_xor = 1'b0;
    int         sl_delay = 3;
    logic [W-1:0] sl_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Behavioural slave: answers sl_delay cycles after the strobe unless sl_never.
    initial begin
        acc_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (s_uprs || s_upws)) begin
                e.c_iss = cyc;
                e.gnt   = grant;
                e.wr    = s_upws;
                e.addr  = s_upa;
                e.wdata = s_updi;
                slog.push_back(e);
                if (!sl_never) begin
                    repeat (sl_delay) @(negedge clk);
                    s_updo  = sl_xor ? (sl_data ^ {{(W-A){1'b0}}, s_upa}) : sl_data;
                    s_uprdy = 1'b1;
                    rdy_log.push_back(cyc);
                    @(negedge clk);
                    s_uprdy = 1'b0;
                    s_updo  = '0;
                end
            end
        end
    end

    // Monitor: every completion pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_uprdy != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rdy", 64'(m_uprdy), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rdy_port", 64'(m_uprdy), 64'(e.port));
                    chk("rdy_err", 64'(m_uperr), e.err ? 64'(e.port) : 64'(0));
                    chk("rdy_data", 64'(m_updo), 64'(e.data));
                    chk("done_grant", 64'(grant), 64'(0));
                    chk("done_upen", 64'(s_upen), 64'(0));
                end
                last_rdy_cyc = cyc;
            end
            if ((m_uperr & ~m_uprdy) != '0)
                chk("err_without_rdy", 64'(m_uperr & ~m_uprdy), 64'(0));
        end
    end

    task automatic setp(input int p, input bit wr, input logic [A-1:0] addr, input logic [W-1:0] data);
        logic [NP-1:0] pm;
        pm = NP'(1) << p;
        m_upen = m_upen | pm;
        if (wr) m_upws = m_upws | pm;
        else    m_uprs = m_uprs | pm;
        m_upa  = (m_upa & ~({{(NP*A-A){1'b0}}, {A{1'b1}}} << (p*A)))
               | ({{(NP*A-A){1'b0}}, addr} << (p*A));
        m_updi = (m_updi & ~({{(NP*W-W){1'b0}}, {W{1'b1}}} << (p*W)))
               | ({{(NP*W-W){1'b0}}, data} << (p*W));
    endtask

    task automatic go();
        t0 = cyc;
        @(posedge clk); #1;
        m_upws = '0;
        m_uprs = '0;
    endtask

    task automatic push_exp(input int p, input bit err, input logic [W-1:0] d);
        exp_t e;
        e.port = NP'(1) << p;
        e.err  = err;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic exp_rd(input int p, input logic [W-1:0] d);
        exp_updo = d;
        push_exp(p, 1'b0, d);
    endtask

    task automatic exp_wr(input int p, input bit err);
        push_exp(p, err, exp_updo);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: pending=%0d required=0", name, sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string name);
        @(posedge clk); #1;
        rst_n  = 1'b0;
        m_upen = '0;
        m_upws = '0;
        m_uprs = '0;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_updo"}, 64'(m_updo), 64'(0));
        chk({name, "_rdy_err"}, 64'({m_uprdy, m_uperr}), 64'(0));
        chk({name, "_grant_busy"}, 64'({grant, busy}), 64'(0));
        chk({name, "_s_ctl"}, 64'({s_upen, s_upws, s_uprs}), 64'(0));
        chk({name, "_s_upa"}, 64'(s_upa), 64'(0));
        chk({name, "_s_updi"}, 64'(s_updi), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        slog.delete();
        rdy_log.delete();
        exp_updo = '0;
    endtask

    initial begin
        do_reset("rst0");

        // Single read, slave answers three cycles after the strobe.
        sl_never = 1'b0; sl_xor = 1'b0; sl_delay = 3; sl_data = 32'h1234_5678;
        setp(0, 1'b0, 30'h10, 32'h0);
        exp_rd(0, 32'h1234_5678);
        go();
        wait_done("t1", 60);
        m_upen = '0;
        chk("t1_acc_count", 64'(slog.size()), 64'(1));
        if (slog.size() == 1 && rdy_log.size() == 1) begin
            chk("t1_strobe_to_issue", 64'(slog[0].c_iss - t0), 64'(2));
            chk("t1_addr", 64'(slog[0].addr), 64'h10);
            chk("t1_is_read", 64'(slog[0].wr), 64'(0));
            chk("t1_grant", 64'(slog[0].gnt), 64'(1));
            chk("t1_rdy_to_uprdy", 64'(last_rdy_cyc - rdy_log[0]), 64'(1));
        end

        // Both ports each round: round-robin must alternate 0,1.
        do_reset("rst1");
        sl_xor = 1'b1; sl_data = '0; sl_delay = 1;
        for (int r = 0; r < 3; r++) begin
            setp(0, 1'b0, A'(32'h100 + r), 32'h0);
            setp(1, 1'b1, A'(32'h200 + r), 32'hD0 + r);
            exp_rd(0, 32'h100 + r);
            exp_wr(1, 1'b0);
            go();
            wait_done("t2", 60);
            m_upen = '0;
        end
        chk("t2_acc_count", 64'(slog.size()), 64'(6));
        if (slog.size() == 6 && rdy_log.size() == 6) begin
            for (int k = 0; k < 6; k++)
                chk("t2_grant_order", 64'(slog[k].gnt), (k % 2 == 0) ? 64'(1) : 64'(2));
            for (int k = 1; k < 6; k += 2) begin
                chk("t2_turnaround", 64'(slog[k].c_iss - rdy_log[k-1]), 64'(3));
                chk("t2_wdata", 64'(slog[k].wdata), 64'(32'hD0 + k / 2));
                chk("t2_waddr", 64'(slog[k].addr), 64'(32'h200 + k / 2));
            end
        end

        // Port 1 write, slave silent: timeout 256 cycles after WAIT entry, read data untouched.
        sl_never = 1'b1;
        slog.delete(); rdy_log.delete();
        setp(1, 1'b1, 30'h3A, 32'hBEEF);
        exp_wr(1, 1'b1);
        go();
        wait_done("t3", 320);
        m_upen = '0;
        chk("t3_acc_count", 64'(slog.size()), 64'(1));
        if (slog.size() == 1)
            chk("t3_timeout_cycles", 64'(last_rdy_cyc - slog[0].c_iss), 64'(257));

        // Port 0 read, slave silent: timeout data returned.
        slog.delete();
        setp(0, 1'b0, 30'h3B, 32'h0);
        exp_updo = 32'hCAFE_CAFE;
        push_exp(0, 1'b1, 32'hCAFE_CAFE);
        go();
        wait_done("t4", 320);
        m_upen = '0;
        chk("t4_acc_count", 64'(slog.size()), 64'(1));

        // Ready arrives in the very cycle the counter saturates: ready wins.
        sl_never = 1'b0; sl_xor = 1'b1; sl_data = '0; sl_delay = 256;
        slog.delete(); rdy_log.delete();
        setp(1, 1'b0, 30'h44, 32'h0);
        exp_rd(1, 32'h44);
        go();
        wait_done("t5", 320);
        m_upen = '0;
        if (slog.size() == 1)
            chk("t5_rdy_cycles", 64'(last_rdy_cyc - slog[0].c_iss), 64'(257));
        else
            chk("t5_acc_count", 64'(slog.size()), 64'(1));

        // Port 1 queues behind port 0, then withdraws before being served.
        sl_delay = 5;
        slog.delete(); rdy_log.delete();
        setp(0, 1'b0, 30'h30, 32'h0);
        exp_rd(0, 32'h30);
        go();
        setp(1, 1'b0, 30'h31, 32'h0);
        go();
        @(posedge clk); #1;
        m_upen = m_upen & ~NP'(2);
        wait_done("t6", 60);
        repeat (20) @(posedge clk);
        #1 m_upen = '0;
        @(negedge clk);
        chk("t6_acc_count", 64'(slog.size()), 64'(1));
        chk("t6_idle_after", 64'(busy), 64'(0));
        if (slog.size() == 1)
            chk("t6_grant", 64'(slog[0].gnt), 64'(1));

        // Reset while waiting on a silent slave, then a fresh pair of requests.
        sl_never = 1'b1;
        @(posedge clk); #1;
        setp(1, 1'b0, 30'h55, 32'h0);
        go();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t7_in_wait", 64'({busy, s_upen, grant}), 64'({1'b1, 1'b1, 2'b10}));
        do_reset("rst_wait");
        sl_never = 1'b0; sl_delay = 2;
        setp(0, 1'b0, 30'h70, 32'h0);
        setp(1, 1'b0, 30'h71, 32'h0);
        exp_rd(0, 32'h70);
        exp_rd(1, 32'h71);
        go();
        wait_done("t7", 60);
        m_upen = '0;
        chk("t7_acc_count", 64'(slog.size()), 64'(2));
        if (slog.size() == 2) begin
            chk("t7_first_grant", 64'(slog[0].gnt), 64'(1));
            chk("t7_second_grant", 64'(slog[1].gnt), 64'(2));
        end

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/up_rr_arb.md
UP_RR_ARB -- requirements
Module: up_rr_arb

Interface
REQ-001 Parameter N_PORT, default 2, number of requesting microprocessor-interface masters (legal 2..4).
REQ-002 Parameter G_CPUA, default 30, microprocessor address width.
REQ-003 Parameter G_CPUW, default 32, microprocessor data width.
REQ-004 Parameter TIMEOUT_W, default 8, width of the access timeout counter.
REQ-005 Parameter TIMEOUT_D, default 32'hCAFE_CAFE, read data returned on timeout.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 m_upa  in  N_PORT*G_CPUA  per-port address; port i at slice [i*G_CPUA +: G_CPUA].
REQ-009 m_upen  in  N_PORT  per-port access enable; held high until that port's m_uprdy.
REQ-010 m_upws  in  N_PORT  per-port one-cycle write strobe.
REQ-011 m_uprs  in  N_PORT  per-port one-cycle read strobe.
REQ-012 m_updi  in  N_PORT*G_CPUW  per-port write data; sliced like m_upa.
REQ-013 m_updo  out  G_CPUW  shared read data; valid only with an m_uprdy bit.
REQ-014 m_uprdy  out  N_PORT  per-port one-cycle completion pulse.
REQ-015 m_uperr  out  N_PORT  per-port timeout flag; asserted only together with m_uprdy.
REQ-016 s_upa / s_upen / s_upws / s_uprs / s_updi  out  G_CPUA/1/1/1/G_CPUW  shared slave bus.
REQ-017 s_updo  in  G_CPUW, s_uprdy  in  1  slave read data and ready.
REQ-018 grant  out  N_PORT  one-hot grant of current owner; all-zero when idle.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 A strobe (m_upws[i] or m_uprs[i]) with m_upen[i]=1 shall set pend[i] and pend_wr[i] (1=write, 0=read) at the next edge.
REQ-021 A strobe on a port already pending or granted shall be ignored; m_upws and m_uprs together shall be treated as a write.
REQ-022 m_upen[i] low while pend[i]=1 and not granted shall clear pend[i] (abort); no m_uprdy shall be issued for it.
REQ-023 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-024 IDLE: if any pend, select winner round-robin starting at (last+1) mod N_PORT; register grant, last, s_upa, s_updi from winner; go ISSUE.
REQ-025 ISSUE: s_upen=1, one-cycle s_upws or s_uprs per pend_wr; go WAIT.
REQ-026 WAIT: s_upen=1; timeout counter increments each cycle, cleared on entry to WAIT.
REQ-027 WAIT with s_uprdy=1: register m_updo<=s_updo (reads) or hold (writes), pulse m_uprdy[g], m_uperr[g]=0, clear pend[g], go DONE.
REQ-028 WAIT with counter all-ones and s_uprdy=0: m_updo<=TIMEOUT_D (reads), pulse m_uprdy[g] with m_uperr[g]=1, clear pend[g], go DONE.
REQ-029 s_uprdy and timeout in the same cycle: s_uprdy wins, m_uperr=0.
REQ-030 DONE: s_upen=0, grant=0 for one turnaround cycle; go IDLE.
REQ-031 s_uprdy outside WAIT shall be ignored.
REQ-032 Once granted, m_upen drop shall not abort; access completes and m_uprdy still pulses.
REQ-033 Latency, idle bus: strobe at cycle t -> s_upws/s_uprs at t+2; s_uprdy at u -> m_uprdy at u+1; next s_upen earliest u+3.
REQ-034 s_upa, s_updi held stable from ISSUE through the next grant.

Reset
REQ-035 On rst_n=0: state IDLE, pend/pend_wr=0, last=N_PORT-1 (port 0 first), counter 0.
REQ-036 On rst_n=0: all outputs 0, including m_updo, grant, busy, s_upa, s_updi.
REQ-037 Reset mid-access shall abandon it with no m_uprdy pulse.

Verification
REQ-038 Port 0 read addr 0x10, slave s_uprdy 3 cycles after s_uprs, s_updo 0x12345678 -> m_uprdy[0] pulse, m_updo 0x12345678, m_uperr[0]=0.
REQ-039 Ports 0 and 1 strobe same cycle, three rounds -> grant order 0,1,0,1,0,1; one DONE cycle between accesses.
REQ-040 Port 1 write, slave never ready -> m_uprdy[1] and m_uperr[1] 256 cycles after WAIT entry (TIMEOUT_W=8); m_updo unchanged.
REQ-041 Port 0 read, never ready -> m_updo=0xCAFECAFE, m_uperr[0]=1.
REQ-042 Port 1 pending behind port 0 drops m_upen -> no access for port 1, no m_uprdy[1].
REQ-043 rst_n low during WAIT -> next cycle all outputs 0, no m_uprdy; fresh request after reset served normally, port 0 first.
